tmds_period_encoder: RTL and testbench
======================================

Name: tmds_period_encoder

Overview:
- Parametrised multi-channel TMDS encoder covering every HDMI 1.x period type, not only the DVI video/control periods:
  - video data (DVI 1.0 8b/10b with running disparity)
  - control
  - video guard band
  - data-island guard band
  - TERC4 data island
- Sits between the video/packet timing generator and the OSER10 serializers in the hdmi top.
- One 10-bit symbol per channel per pixel clock.
- Configurable pipeline depth.

Parameters:
- NUM_CH, 3, number of TMDS channels (1..4); channel 0 is the sync-carrying channel.
- PIPE, 1, latency in clocks from inputs to o_tmds (1 or 2); PIPE=2 adds an input register stage.

Ports:
- i_hdmi_clk  in  1  pixel clock
- i_reset  in  1  asynchronous reset, active high
- i_mode  in  3  period type for this cycle: 0=CTRL, 1=VIDEO, 2=VIDEO_GUARD, 3=DATA_GUARD, 4=DATA_ISLAND, 5..7 illegal
- i_data  in  8*NUM_CH  video byte per channel; ch k = bits [8k+7:8k]
- i_ctrl  in  2*NUM_CH  control pair {c1,c0} per channel; ch0 = {vsync,hsync}
- i_aux  in  4*NUM_CH  TERC4 nibble per channel
- o_tmds  out  10*NUM_CH  encoded symbol per channel; bit 0 is serialized first
- o_mode_err  out  1  sticky flag: an illegal/unsupported mode was presented

Behaviour:
- Reset (async assert; deassert sampled on i_hdmi_clk):
  - every channel of o_tmds = 10'b1101010100 (control 00)
  - all disparity counters = 0
  - o_mode_err = 0
  - PIPE=2 input stage cleared to mode CTRL, ctrl 00.
- Latency: exactly PIPE cycles. Inputs sampled at edge n appear on o_tmds after edge n+PIPE-1.
- CTRL:
  - Per-channel control code, written q[9:0]: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - Disparity counter of that channel cleared to 0.
- VIDEO (DVI 1.0 algorithm per channel; per-channel signed 5-bit counter cnt):
  - Transition-minimize: N1(d) = ones in d.
    - If N1>4, or N1==4 and d[0]==0: use XNOR chain, q_m[8]=0.
    - Otherwise: use XOR chain, q_m[8]=1.
    - q_m[0]=d[0].
  - N1q/N0q = ones/zeros of q_m[7:0].
  - If cnt==0 or N1q==N0q:
    - q[9] = ~q_m[8]
    - q[8] = q_m[8]
    - q[7:0] = q_m[8] ? q_m : ~q_m
    - cnt += q_m[8] ? N1q-N0q : N0q-N1q
  - Else if (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - q = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] + N0q - N1q
  - Else:
    - q = {0, q_m[8], q_m[7:0]}
    - cnt += -2*(~q_m[8]) + N1q - N0q
  - Counter arithmetic is 5-bit two's complement. The range stays within ±16 by construction; no saturation logic.
- VIDEO_GUARD:
  - ch0 = 1011001100, ch1 = 0100110011, ch2 = 1011001100, ch3 = control code from i_ctrl.
  - cnt cleared.
- DATA_GUARD:
  - ch0 = TERC4({1,1,c1,c0}) from ch0 i_ctrl.
  - ch1 and ch2 = 0100110011.
  - ch3 = control code.
  - cnt cleared.
- DATA_ISLAND: each channel = TERC4(i_aux nibble); cnt cleared. TERC4 table, nibble→q[9:0]:
  - 0:1010011100, 1:1001100011, 2:1011100100, 3:1011100010
  - 4:0101110001, 5:0100011110, 6:0110001110, 7:0100111100
  - 8:1011001100, 9:0100111001, A:0110011100, B:1011000110
  - C:1010001110, D:1001110001, E:0101100011, F:1011000011
- Illegal mode (5..7): behaves as CTRL with i_ctrl; o_mode_err set and held until reset.
- Mode may change every cycle. The first VIDEO cycle after any non-VIDEO cycle always starts from cnt=0.
- Reset mid-stream overrides everything immediately (async); no partial symbol is emitted.

Optional Feature:
- Macro: TMDS_TERC4_EN.
- Defined: DATA_GUARD and DATA_ISLAND behave as above.
- Undefined:
  - No TERC4 logic is synthesized; i_aux is ignored.
  - Modes 3 and 4 are treated as illegal: control code output, cnt cleared, o_mode_err set.
  - Yields a DVI-only encoder.

Test Plan:
- Reset released, mode CTRL, ch0 ctrl=00 → o_tmds ch0 = 0x354 held; o_mode_err=0.
- Mode VIDEO, d=0x00 on ch0 for 3 cycles from cnt=0 → ch0 outputs 0x100, 0x3FF, 0x100 in order (cnt −8, +2, −6).
- VIDEO 0x00 ×2, one CTRL cycle, VIDEO 0x00 → post-CTRL symbol is 0x100 (disparity cleared).
- VIDEO_GUARD → ch0/ch1/ch2 = 1011001100 / 0100110011 / 1011001100. DATA_GUARD with ch0 ctrl=2'b01 → ch0 = TERC4(0xD) = 1001110001.
- DATA_ISLAND with aux nibbles 0x0, 0x7, 0xF → 1010011100, 0100111100, 1011000011. Build without TMDS_TERC4_EN → control codes and o_mode_err=1.
- PIPE=2, mode 6 then reset asserted mid-stream → o_mode_err 1 two cycles after mode 6; async reset clears all outputs to 0x354 / 0 without waiting for a clock edge.

Source files
------------

// File: rtl/tmds_period_encoder.sv
// Multi-channel HDMI TMDS encoder: video (8b/10b with running disparity), control,
// guard-band and data-island periods. TERC4 periods exist only with TMDS_TERC4_EN defined.
module tmds_period_encoder #(
    parameter int NUM_CH = 3,
    parameter int PIPE   = 1
) (
    input  logic                 i_hdmi_clk,
    input  logic                 i_reset,
    input  logic [2:0]           i_mode,
    input  logic [8*NUM_CH-1:0]  i_data,
    input  logic [2*NUM_CH-1:0]  i_ctrl,
    input  logic [4*NUM_CH-1:0]  i_aux,
    output logic [10*NUM_CH-1:0] o_tmds,
    output logic                 o_mode_err
);

    localparam logic [2:0] MODE_CTRL        = 3'd0;
    localparam logic [2:0] MODE_VIDEO       = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GUARD = 3'd2;
    localparam logic [2:0] MODE_DATA_GUARD  = 3'd3;
    localparam logic [2:0] MODE_DATA_ISLAND = 3'd4;

    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] GB_EVEN  = 10'b1011001100;
    localparam logic [9:0] GB_ODD   = 10'b0100110011;

    typedef struct packed {
        logic [9:0]        sym;
        logic signed [4:0] cnt;
    } enc_t;

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   ctrl_code = 10'b1101010100;
            2'b01:   ctrl_code = 10'b0010101011;
            2'b10:   ctrl_code = 10'b0101010100;
            default: ctrl_code = 10'b1010101011;
        endcase
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] n);
        case (n)
            4'h0:    terc4 = 10'b1010011100;
            4'h1:    terc4 = 10'b1001100011;
            4'h2:    terc4 = 10'b1011100100;
            4'h3:    terc4 = 10'b1011100010;
            4'h4:    terc4 = 10'b0101110001;
            4'h5:    terc4 = 10'b0100011110;
            4'h6:    terc4 = 10'b0110001110;
            4'h7:    terc4 = 10'b0100111100;
            4'h8:    terc4 = 10'b1011001100;
            4'h9:    terc4 = 10'b0100111001;
            4'hA:    terc4 = 10'b0110011100;
            4'hB:    terc4 = 10'b1011000110;
            4'hC:    terc4 = 10'b1010001110;
            4'hD:    terc4 = 10'b1001110001;
            4'hE:    terc4 = 10'b0101100011;
            default: terc4 = 10'b1011000011;
        endcase
    endfunction
`endif

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            s = s + {3'b000, v[i]};
        return s;
    endfunction

    // DVI 1.0 video encoder: transition minimisation followed by DC balancing.
    function automatic enc_t encode_video(input logic [7:0] d, input logic signed [4:0] cnt);
        logic [8:0]        q_m;
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic [3:0]        n0q;
        logic signed [4:0] bal;
        logic              use_xnor;
        enc_t              r;
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
        q_m[0]   = d[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        q_m[8] = ~use_xnor;
        n1q    = ones8(q_m[7:0]);
        n0q    = 4'd8 - n1q;
        bal    = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
        if (cnt == 5'sd0 || bal == 5'sd0) begin
            r.sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            r.cnt = q_m[8] ? cnt + bal : cnt - bal;
        end else if ((cnt > 5'sd0 && bal > 5'sd0) || (cnt < 5'sd0 && bal < 5'sd0)) begin
            r.sym = {1'b1, q_m[8], ~q_m[7:0]};
            r.cnt = cnt - bal + (q_m[8] ? 5'sd2 : 5'sd0);
        end else begin
            r.sym = {1'b0, q_m[8], q_m[7:0]};
            r.cnt = cnt + bal - (q_m[8] ? 5'sd0 : 5'sd2);
        end
        return r;
    endfunction

    logic [2:0]          s_mode;
    logic [8*NUM_CH-1:0] s_data;
    logic [2*NUM_CH-1:0] s_ctrl;
`ifdef TMDS_TERC4_EN
    logic [4*NUM_CH-1:0] s_aux;
`else
    logic unused_aux;
    assign unused_aux = ^i_aux;
`endif

    generate
        if (PIPE == 2) begin : g_in_reg
            always_ff @(posedge i_hdmi_clk or posedge i_reset) begin
                if (i_reset) begin
                    s_mode <= MODE_CTRL;
                    s_data <= '0;
                    s_ctrl <= '0;
`ifdef TMDS_TERC4_EN
                    s_aux  <= '0;
`endif
                end else begin
                    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
                    s_mode <= i_mode;
                    s_data <= i_data;
                    s_ctrl <= i_ctrl;
`ifdef TMDS_TERC4_EN
                    s_aux  <= i_aux;
`endif
                end
            end
        end else begin : g_in_wire
            always_comb begin
                s_mode = i_mode;
                s_data = i_data;
                s_ctrl = i_ctrl;
`ifdef TMDS_TERC4_EN
                s_aux  = i_aux;
`endif
            end
        end
    endgenerate

    logic mode_legal;
    always_comb begin
`ifdef TMDS_TERC4_EN
        mode_legal = (s_mode <= MODE_DATA_ISLAND);
`else
        mode_legal = (s_mode <= MODE_VIDEO_GUARD);
`endif
    end

    logic [NUM_CH-1:0][9:0] sym_d;
    logic [NUM_CH-1:0][9:0] sym_q;
    logic signed [4:0]      cnt_d [NUM_CH];
    logic signed [4:0]      cnt_q [NUM_CH];

    // Every non-video period clears disparity, so video always restarts balanced.
    always_comb begin
        enc_t enc;
        for (int k = 0; k < NUM_CH; k++) begin
            // NOTE: defaults first on every path keep this block purely combinational (no latches).
            enc      = encode_video(s_data[8*k +: 8], cnt_q[k]);
            sym_d[k] = ctrl_code(s_ctrl[2*k +: 2]);
            cnt_d[k] = 5'sd0;
            case (s_mode)
                MODE_VIDEO: begin
                    sym_d[k] = enc.sym;
                    cnt_d[k] = enc.cnt;
                end
                MODE_VIDEO_GUARD: begin
                    if (k == 1)
                        sym_d[k] = GB_ODD;
                    else if (k != 3)
                        sym_d[k] = GB_EVEN;
                end
`ifdef TMDS_TERC4_EN
                MODE_DATA_GUARD: begin
                    if (k == 0)
                        sym_d[k] = terc4({2'b11, s_ctrl[1:0]});
                    else if (k != 3)
                        sym_d[k] = GB_ODD;
                end
                MODE_DATA_ISLAND: begin
                    sym_d[k] = terc4(s_aux[4*k +: 4]);
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_hdmi_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sym_q[k] <= CTRL_00;
                cnt_q[k] <= 5'sd0;
            end
            o_mode_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                sym_q[k] <= sym_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            if (!mode_legal)
                o_mode_err <= 1'b1;
        end
    end

    assign o_tmds = sym_q;

endmodule

// File: tb/tb_tmds_period_encoder.sv
// Scoreboard bench for tmds_period_encoder: PIPE=1 and PIPE=2 instances share directed
// stimulus; expected symbols are queued per vector and compared when each output is due.
module tb_tmds_period_encoder;

    localparam int NUM_CH = 4;

    localparam logic [39:0] EXP_RST   = {4{10'h354}};
    localparam logic [39:0] EXP_E4    = {10'h2AB, 10'h154, 10'h0AB, 10'h354};
    localparam logic [39:0] EXP_E5    = {10'h2AB, 10'h154, 10'h0AB, 10'h0AB};
    localparam logic [31:0] D_A       = 32'h0100FF00;
    localparam logic [39:0] V1        = {10'h1FF, 10'h100, 10'h200, 10'h100};
    localparam logic [39:0] V2        = {10'h300, 10'h3FF, 10'h0FF, 10'h3FF};
    localparam logic [39:0] V3        = {10'h300, 10'h100, 10'h0FF, 10'h100};
    localparam logic [31:0] D_B       = 32'h1E1E1E1E;
    localparam logic [39:0] VB1       = {4{10'h25F}};
    localparam logic [39:0] VB2       = {4{10'h0A0}};
    localparam logic [39:0] EXP_VGB   = {10'h2AB, 10'h2CC, 10'h133, 10'h2CC};
    localparam logic [39:0] EXP_DGB   = {10'h2AB, 10'h133, 10'h133, 10'h271};
    localparam logic [39:0] EXP_ISL   = {10'h11E, 10'h2C3, 10'h13C, 10'h29C};
    localparam logic [15:0] AUX_ISL   = 16'h5F70;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic [15:0] aux;
    logic [39:0] tmds1, tmds2;
    logic        err1, err2;

    always #5 clk = ~clk;

    tmds_period_encoder #(.NUM_CH(NUM_CH), .PIPE(1)) dut1 (
        .i_hdmi_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_aux(aux), .o_tmds(tmds1), .o_mode_err(err1)
    );

    tmds_period_encoder #(.NUM_CH(NUM_CH), .PIPE(2)) dut2 (
        .i_hdmi_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_aux(aux), .o_tmds(tmds2), .o_mode_err(err2)
    );

    typedef struct {
        int          due;
        int          idx;
        logic [40:0] exp;
    } item_t;

    item_t q1[$];
    item_t q2[$];
    int    cyc     = 0;
    int    checks  = 0;
    int    errors  = 0;
    int    vec_idx = 0;
    logic  err_exp = 1'b0;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got err/tmds %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output due at this edge is popped and compared.
    always @(posedge clk) begin
        item_t it;
        cyc++;
        #1;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            it = q1.pop_front();
            check($sformatf("pipe1 vec%0d", it.idx), {err1, tmds1}, it.exp);
        end
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            it = q2.pop_front();
            check($sformatf("pipe2 vec%0d", it.idx), {err2, tmds2}, it.exp);
        end
    end

    task automatic apply(input logic [2:0] m, input logic [31:0] d, input logic [7:0] c,
                         input logic [15:0] a, input logic [39:0] exp);
        item_t it;
        @(negedge clk);
        mode = m;
        data = d;
        ctrl = c;
        aux  = a;
`ifdef TMDS_TERC4_EN
        if (m > 3'd4) err_exp = 1'b1;
`else
        if (m > 3'd2) err_exp = 1'b1;
`endif
        it.idx = vec_idx;
        it.exp = {err_exp, exp};
        it.due = cyc + 1;
        q1.push_back(it);
        it.due = cyc + 2;
        q2.push_back(it);
        vec_idx++;
    endtask

    task automatic mid_stream_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("pipe1 async reset", {err1, tmds1}, {1'b0, EXP_RST});
        check("pipe2 async reset", {err2, tmds2}, {1'b0, EXP_RST});
        q1.delete();
        q2.delete();
        err_exp = 1'b0;
        mode = 3'd0;
        data = '0;
        ctrl = '0;
        aux  = '0;
        @(posedge clk);
        #2;
        check("pipe1 reset held", {err1, tmds1}, {1'b0, EXP_RST});
        check("pipe2 reset held", {err2, tmds2}, {1'b0, EXP_RST});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        mode = 3'd0;
        data = '0;
        ctrl = '0;
        aux  = '0;
        #2;
        check("pipe1 reset state", {err1, tmds1}, {1'b0, EXP_RST});
        check("pipe2 reset state", {err2, tmds2}, {1'b0, EXP_RST});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        apply(3'd0, '0,  8'h00, '0, EXP_RST);
        apply(3'd0, '0,  8'h00, '0, EXP_RST);
        apply(3'd0, '0,  8'hE4, '0, EXP_E4);

        apply(3'd1, D_A, 8'hE4, '0, V1);
        apply(3'd1, D_A, 8'hE4, '0, V2);
        apply(3'd1, D_A, 8'hE4, '0, V3);

        apply(3'd0, '0,  8'hE4, '0, EXP_E4);
        apply(3'd1, D_A, 8'hE4, '0, V1);
        apply(3'd1, D_A, 8'hE4, '0, V2);
        apply(3'd0, '0,  8'hE4, '0, EXP_E4);
        apply(3'd1, D_A, 8'hE4, '0, V1);

        apply(3'd2, '0,  8'hE4, '0, EXP_VGB);
        apply(3'd1, D_A, 8'hE4, '0, V1);
        apply(3'd2, '0,  8'hE4, '0, EXP_VGB);
        apply(3'd1, D_B, 8'hE4, '0, VB1);
        apply(3'd1, D_B, 8'hE4, '0, VB2);
        apply(3'd1, D_B, 8'hE4, '0, VB1);

`ifdef TMDS_TERC4_EN
        apply(3'd3, '0,  8'hE5, AUX_ISL, EXP_DGB);
        apply(3'd4, '0,  8'hE5, AUX_ISL, EXP_ISL);
`else
        apply(3'd3, '0,  8'hE5, AUX_ISL, EXP_E5);
        apply(3'd4, '0,  8'hE5, AUX_ISL, EXP_E5);
`endif
        apply(3'd1, D_A, 8'hE5, AUX_ISL, V1);

        apply(3'd6, D_A, 8'hE4, '0, EXP_E4);
        apply(3'd6, D_A, 8'hE4, '0, EXP_E4);
        apply(3'd0, '0,  8'hE4, '0, EXP_E4);

        mid_stream_reset();

        apply(3'd0, '0,  8'h00, '0, EXP_RST);
        apply(3'd1, D_A, 8'h00, '0, V1);
        apply(3'd1, D_A, 8'h00, '0, V2);
        apply(3'd1, D_A, 8'h00, '0, V3);
        apply(3'd7, '0,  8'hE4, '0, EXP_E4);
        apply(3'd0, '0,  8'h00, '0, EXP_RST);
        apply(3'd0, '0,  8'h00, '0, EXP_RST);

        for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++)
            @(posedge clk);
        #3;
        check("queue drain", 41'(q1.size() + q2.size()), 41'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
